// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory port arbiter.
//   - FSM state encoding (IDLE, LOAD)
//   - default word width, memory cell width and memory depth
package imem_pkg;

  localparam int IMEM_WORD_LEN  = 32;
  localparam int IMEM_CELL_SIZE = 8;
  localparam int IMEM_MEM_SIZE  = 256;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } imem_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset, clears count
//   inc    in   increment request for this cycle
//   count  out  current value, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates a single instruction-memory port between the IF stage (reads)
// and the program loader (cell writes). The loader has priority; once a
// loader burst starts, the port stays with the loader until ld_last.
//
// Optional feature macro: IMEM_FAIRNESS_EN
//   When defined, a fetch is forced through after every 8 consecutive loader
//   grants seen while if_req is high, even in the middle of a burst.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   if_req, if_addr     fetch request and byte address
//   if_gnt              fetch granted this cycle
//   if_valid            one-cycle pulse, if_instr/if_err valid
//   if_instr, if_err    fetched word, misaligned-address flag
//   ld_req, ld_addr,
//   ld_data, ld_last    loader write beat and end-of-burst marker
//   ld_gnt              loader beat accepted this cycle
//   ld_count            saturating count of accepted loader beats
//   mem_addr, mem_we,
//   mem_wdata           memory port driven from the granted requester
//   mem_rdata           combinational 4-cell read data at mem_addr
//
// state | meaning
// IDLE  | no burst open; loader wins over fetch, fetch served otherwise
// LOAD  | burst open; only loader beats granted (fairness fetch excepted)
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int WORD_LEN       = IMEM_WORD_LEN,
  parameter int MEM_CELL_SIZE  = IMEM_CELL_SIZE,
  parameter int INSTR_MEM_SIZE = IMEM_MEM_SIZE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              if_req,
  input  logic [WORD_LEN-1:0]               if_addr,
  output logic                              if_gnt,
  output logic                              if_valid,
  output logic [WORD_LEN-1:0]               if_instr,
  output logic                              if_err,
  input  logic                              ld_req,
  input  logic [WORD_LEN-1:0]               ld_addr,
  input  logic [MEM_CELL_SIZE-1:0]          ld_data,
  input  logic                              ld_last,
  output logic                              ld_gnt,
  output logic [15:0]                       ld_count,
  output logic [$clog2(INSTR_MEM_SIZE)-1:0] mem_addr,
  output logic                              mem_we,
  output logic [MEM_CELL_SIZE-1:0]          mem_wdata,
  input  logic [WORD_LEN-1:0]               mem_rdata
);

  localparam int AW = $clog2(INSTR_MEM_SIZE);

  imem_state_e         state_q, state_d;
  logic                if_valid_q, if_valid_d;
  logic [WORD_LEN-1:0] if_instr_q, if_instr_d;
  logic                if_err_q, if_err_d;

  logic fetch_gnt;
  logic load_gnt;
  logic fair_fetch;

  // Address bits above the memory depth are dropped so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[WORD_LEN-1:AW], ld_addr[WORD_LEN-1:AW]};

`ifdef IMEM_FAIRNESS_EN
  localparam logic [2:0] FAIR_LAST = 3'd7;

  logic [2:0] fair_cnt_q, fair_cnt_d;
  logic       fair_pend_q, fair_pend_d;

  // A pending fairness slot is only used if the fetch is still wanted.
  assign fair_fetch = fair_pend_q && if_req;

  // The 3-bit count wraps to zero on the 8th grant, which doubles as the
  // clear; the pending flag carries the forced fetch into the next cycle.
  always_comb begin
    fair_cnt_d  = fair_cnt_q;
    fair_pend_d = 1'b0;
    if (!if_req || fetch_gnt) begin
      fair_cnt_d = 3'd0;
    end else if (load_gnt) begin
      fair_cnt_d  = fair_cnt_q + 3'd1;
      fair_pend_d = (fair_cnt_q == FAIR_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fair_cnt_q  <= 3'd0;
      fair_pend_q <= 1'b0;
    end else begin
      fair_cnt_q  <= fair_cnt_d;
      fair_pend_q <= fair_pend_d;
    end
  end
`else
  assign fair_fetch = 1'b0;
`endif

  // Grants are suppressed while reset is held so an abandoned burst cannot
  // slip a write through before reset is released.
  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (!rst) begin
      if (fair_fetch) begin
        fetch_gnt = 1'b1;
      end else if (ld_req) begin
        load_gnt = 1'b1;
      end else if (if_req && (state_q == IDLE)) begin
        fetch_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (load_gnt) begin
      state_d = ld_last ? IDLE : LOAD;
    end
  end

  always_comb begin
    if_valid_d = fetch_gnt;
    if_instr_d = if_instr_q;
    if_err_d   = if_err_q;
    if (fetch_gnt) begin
      if_instr_d = mem_rdata;
      if_err_d   = (if_addr[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_err_q   <= if_err_d;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (load_gnt) begin
      mem_we    = 1'b1;
      mem_addr  = ld_addr[AW-1:0];
      mem_wdata = ld_data;
    end else if (fetch_gnt) begin
      mem_addr = if_addr[AW-1:0];
    end
  end

  sat_counter #(
    .WIDTH(16)
  ) u_ld_count (
    .clk  (clk),
    .rst  (rst),
    .inc  (load_gnt),
    .count(ld_count)
  );

  assign if_gnt   = fetch_gnt;
  assign ld_gnt   = load_gnt;
  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_err   = if_err_q;

endmodule
